gate_interlock: RTL

- Sits between the discharge MOSFET controller and the gate-driver pins.
- Receives the requested gate commands for the four half-bridge legs (buck1, buck2, res1, res2) and the deion switch, and drives the physical gates.
- Enforces a minimum dead time per leg, rejects illegal shoot-through commands, limits continuous upper-switch on-time, and trips on fast overcurrent.
- Once tripped, it latches a fault with a cause code and holds every gate off until the fault is explicitly cleared.

---
 rtl/gate_interlock_pkg.sv | 34 +++
 rtl/gate_interlock_if.sv | 30 +++
 rtl/gate_interlock_leg_deadtime.sv | 58 +++++
 rtl/gate_interlock.sv | 138 +++++++++++++
 4 files changed

// File: rtl/gate_interlock_pkg.sv
// Shared constants, fault bit positions and global state encoding for the gate interlock.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gate_interlock_pkg;

   // Requested {upper, lower} leg commands
   localparam logic [1:0] LEG_OFF     = 2'b00;
   localparam logic [1:0] LEG_LOW     = 2'b01;
   localparam logic [1:0] LEG_UP      = 2'b10;
   localparam logic [1:0] LEG_ILLEGAL = 2'b11;

   // Bit positions inside fault_code
   localparam int FB_ILLEGAL     = 0;
   localparam int FB_OVERCURRENT = 1;
   localparam int FB_WATCHDOG    = 2;

   // Timing and trip limits (one cycle = 10 ns)
   localparam logic [15:0]        DEAD_TIME    = 16'd10;
   localparam logic [15:0]        MAX_ON_TIME  = 16'd500;
   localparam logic signed [15:0] TRIP_CURRENT = 16'sd90;
   localparam logic [7:0]         TRIP_FILTER  = 8'd4;

   typedef enum logic [1:0] {
      G_RUN     = 2'd0,
      G_FAULT   = 2'd1,
      G_RECOVER = 2'd2
   } g_state_t;

   // Increment that stops at lim
   function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [15:0] lim);
      return (v >= lim) ? lim : v + 16'd1;
   endfunction

endpackage

// File: rtl/gate_interlock_if.sv
// Command/gate bundle between the MOSFET controller (master) and the interlock (slave).
// Latency: n/a (wiring only).
// Backpressure: none; commands are level-sampled every cycle.
interface gate_interlock_if;
   logic [1:0]         cmd_buck1;
   logic [1:0]         cmd_buck2;
   logic [1:0]         cmd_res1;
   logic [1:0]         cmd_res2;
   logic               cmd_deion;
   logic signed [15:0] sample_current;
   logic               fault_clear;
   logic [1:0]         gate_buck1;
   logic [1:0]         gate_buck2;
   logic [1:0]         gate_res1;
   logic [1:0]         gate_res2;
   logic               gate_deion;
   logic               fault;
   logic [2:0]         fault_code;
   logic [15:0]        dt_insert_cnt;

   modport master (
      output cmd_buck1, cmd_buck2, cmd_res1, cmd_res2, cmd_deion, sample_current, fault_clear,
      input  gate_buck1, gate_buck2, gate_res1, gate_res2, gate_deion, fault, fault_code, dt_insert_cnt
   );

   modport slave (
      input  cmd_buck1, cmd_buck2, cmd_res1, cmd_res2, cmd_deion, sample_current, fault_clear,
      output gate_buck1, gate_buck2, gate_res1, gate_res2, gate_deion, fault, fault_code, dt_insert_cnt
   );
endinterface

// File: rtl/gate_interlock_leg_deadtime.sv
// One half-bridge leg: dead-time enforcement, shoot-through rejection, upper on-time watchdog.
// Latency: 1 cycle command-to-gate once the complementary switch has been off DEAD_TIME cycles.
// Backpressure: none; blocked turn-ons simply hold the gate low and pulse o_blocked once.
module leg_deadtime
   import gate_interlock_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] i_cmd,
   input  logic       i_force_off,
   output logic [1:0] o_gate,
   output logic       o_illegal,
   output logic       o_blocked,
   output logic       o_watchdog
);

   logic [1:0]  r_gate;
   logic [15:0] r_up_off;
   logic [15:0] r_lo_off;
   logic [15:0] r_up_run;
   logic        r_blk_up;
   logic        r_blk_lo;

   logic w_up_ok, w_lo_ok, w_up_nxt, w_lo_nxt, w_blk_up, w_blk_lo;

   // A switch may turn on only when its complement has been off for the full dead time
   assign w_up_ok    = (i_cmd == LEG_UP)  && (r_lo_off >= DEAD_TIME);
   assign w_lo_ok    = (i_cmd == LEG_LOW) && (r_up_off >= DEAD_TIME);
   assign o_watchdog = r_gate[1] && (r_up_run >= MAX_ON_TIME);
   assign w_up_nxt   = w_up_ok && !i_force_off && !o_watchdog;
   assign w_lo_nxt   = w_lo_ok && !i_force_off;
   // Requested but held back purely by dead time
   assign w_blk_up   = (i_cmd == LEG_UP)  && !w_up_ok && !i_force_off;
   assign w_blk_lo   = (i_cmd == LEG_LOW) && !w_lo_ok && !i_force_off;
   assign o_blocked  = (w_blk_up && !r_blk_up) || (w_blk_lo && !r_blk_lo);
   assign o_illegal  = (i_cmd == LEG_ILLEGAL);
   assign o_gate     = r_gate;

   // Gate registers, off-time counters (count includes the current off cycle) and upper run counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gate   <= LEG_OFF;
         r_up_off <= DEAD_TIME;
         r_lo_off <= DEAD_TIME;
         r_up_run <= 16'd0;
         r_blk_up <= 1'b0;
         r_blk_lo <= 1'b0;
      end else begin
         r_gate   <= {w_up_nxt, w_lo_nxt};
         r_up_off <= w_up_nxt ? 16'd0 : sat_inc(r_up_off, DEAD_TIME);
         r_lo_off <= w_lo_nxt ? 16'd0 : sat_inc(r_lo_off, DEAD_TIME);
         r_up_run <= w_up_nxt ? sat_inc(r_up_run, MAX_ON_TIME) : 16'd0;
         r_blk_up <= w_blk_up;
         r_blk_lo <= w_blk_lo;
      end
   end

endmodule

// File: rtl/gate_interlock.sv
// Safety interlock between discharge controller and gate drivers: dead time, shoot-through, watchdog, overcurrent.
// Latency: 1 cycle command-to-gate; trips force all gates off on the same edge the cause is registered.
// Backpressure: none; while faulted or recovering all gates are held low and commands are ignored.
module gate_interlock
   import gate_interlock_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   gate_interlock_if.slave bus
);

   g_state_t    r_state;
   logic        r_fault;
   logic [2:0]  r_code;
   logic [15:0] r_rec_cnt;
   logic [7:0]  r_oc_cnt;
   logic [15:0] r_dt_cnt;
   logic        r_deion;

   logic [1:0]  w_cmd  [4];
   logic [1:0]  w_gate [4];
   logic [3:0]  w_illegal, w_blk, w_wd;
   logic [2:0]  w_cause;
   logic [2:0]  w_blk_n;
   logic [16:0] w_sext, w_mag, w_dt_sum;
   logic [17:0] w_dbl;
   logic        w_over, w_oc, w_run, w_rec_done, w_trip, w_force, w_no_up, w_clear_ok;

   assign w_cmd[0] = bus.cmd_buck1;
   assign w_cmd[1] = bus.cmd_buck2;
   assign w_cmd[2] = bus.cmd_res1;
   assign w_cmd[3] = bus.cmd_res2;

   for (genvar gi = 0; gi < 4; gi++) begin : g_leg
      leg_deadtime u_leg (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_cmd      (w_cmd[gi]),
         .i_force_off(w_force),
         .o_gate     (w_gate[gi]),
         .o_illegal  (w_illegal[gi]),
         .o_blocked  (w_blk[gi]),
         .o_watchdog (w_wd[gi])
      );
   end

   // |sample| is formed in 17 bits so -32768 stays representable; doubling widens to 18
   assign w_sext = {bus.sample_current[15], bus.sample_current};
   assign w_mag  = w_sext[16] ? (~w_sext + 17'd1) : w_sext;
   assign w_dbl  = {w_mag, 1'b0};
   assign w_over = w_dbl > {2'b00, TRIP_CURRENT};
   assign w_oc   = (r_oc_cnt == TRIP_FILTER);

   assign w_cause[FB_ILLEGAL]     = |w_illegal;
   assign w_cause[FB_OVERCURRENT] = w_oc;
   assign w_cause[FB_WATCHDOG]    = |w_wd;

   assign w_run      = (r_state == G_RUN);
   assign w_rec_done = (r_state == G_RECOVER) && (r_rec_cnt == DEAD_TIME - 16'd1);
   assign w_trip     = w_run && (|w_cause);
   // Gates may follow commands on the edge that enters RUN, so recovery holds them low exactly DEAD_TIME cycles
   assign w_force    = w_trip || !(w_run || w_rec_done);
   assign w_no_up    = !(w_cmd[0][1] | w_cmd[1][1] | w_cmd[2][1] | w_cmd[3][1]);
   assign w_clear_ok = bus.fault_clear && w_no_up && (r_oc_cnt == 8'd0);

   assign w_blk_n  = 3'(w_blk[0]) + 3'(w_blk[1]) + 3'(w_blk[2]) + 3'(w_blk[3]);
   assign w_dt_sum = {1'b0, r_dt_cnt} + {14'd0, w_blk_n};

   // Global run/fault/recover sequencing with latched fault and sticky cause code
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= G_RECOVER;
         r_fault   <= 1'b0;
         r_code    <= 3'b000;
         r_rec_cnt <= 16'd0;
      end else begin
         case (r_state)
            G_RUN: begin
               if (w_trip) begin
                  r_state <= G_FAULT;
                  r_fault <= 1'b1;
                  r_code  <= r_code | w_cause;
               end
            end
            G_FAULT: begin
               if (w_clear_ok) begin
                  r_state   <= G_RECOVER;
                  r_fault   <= 1'b0;
                  r_code    <= 3'b000;
                  r_rec_cnt <= 16'd0;
               end else begin
                  r_code <= r_code | w_cause;
               end
            end
            G_RECOVER: begin
               if (w_rec_done) begin
                  r_state   <= G_RUN;
                  r_rec_cnt <= 16'd0;
               end else begin
                  r_rec_cnt <= r_rec_cnt + 16'd1;
               end
            end
            default: r_state <= G_RECOVER;
         endcase
      end
   end

   // Overcurrent filter: consecutive over-threshold cycles, parked at the trip count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_oc_cnt <= 8'd0;
      else if (!w_over)
         r_oc_cnt <= 8'd0;
      else if (r_oc_cnt != TRIP_FILTER)
         r_oc_cnt <= r_oc_cnt + 8'd1;
   end

   // Dead-time insertion counter (reset-only clear, saturating) and deion gate
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dt_cnt <= 16'd0;
         r_deion  <= 1'b0;
      end else begin
         r_dt_cnt <= w_dt_sum[16] ? 16'hFFFF : w_dt_sum[15:0];
         r_deion  <= w_force ? 1'b0 : bus.cmd_deion;
      end
   end

   assign bus.gate_buck1    = w_gate[0];
   assign bus.gate_buck2    = w_gate[1];
   assign bus.gate_res1     = w_gate[2];
   assign bus.gate_res2     = w_gate[3];
   assign bus.gate_deion    = r_deion;
   assign bus.fault         = r_fault;
   assign bus.fault_code    = r_code;
   assign bus.dt_insert_cnt = r_dt_cnt;

endmodule
